fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core: owns the architectural fetch PC, issues word reads to a latency-tolerant instruction memory, and loads the IF/ID pipeline register (`ID_PC`, `ID_instr`, `ID_valid`). It consumes the redirect produced by next-PC resolution in ID, honours the hazard stall, and squashes wrong-path fetches. It is the receiving end of the next-PC path. Its `IF_PC` output feeds next-PC's `PC` input and `ID_PC` feeds `ID_PC`.

---
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads and loads the IF/ID register.
// Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot redirects (default: redirect kills).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IF_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instr,
  output logic        ID_valid,
  output logic        misalign
);

  typedef enum logic [1:0] {RST, ISSUE, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic        redir_ok;
  logic        kill_now;
  logic        deliver;
  logic [31:0] word;
  logic [31:0] target;

  // Redirect is meaningless before the first fetch and is overridden by stall.
  assign redir_ok = redirect && !stall && (state_q != RST);
  assign target   = {redirect_pc[31:2], 2'b00};

`ifdef BRANCH_DELAY_SLOT_EN
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  assign kill_now = 1'b0;
`else
  assign kill_now = redir_ok;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    misalign_d = 1'b0;
    kill_d     = kill_q;
    hold_d     = hold_q;
    deliver    = 1'b0;
    word       = imem_rdata;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`endif

    case (state_q)
      RST: state_d = ISSUE;
      ISSUE: begin
        // An accepted request cannot be recalled, so a same-cycle kill must consume its response.
        if (imem_ready) begin
          state_d = WAIT;
          kill_d  = kill_now;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || kill_now) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            deliver = 1'b1;
          end
        end else if (kill_now) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (kill_now) begin
          state_d = ISSUE;
        end else if (!stall) begin
          deliver = 1'b1;
          word    = hold_q;
        end
      end
      default: state_d = RST;
    endcase

    if (deliver) begin
      id_pc_d    = pc_q;
      id_instr_d = word;
      id_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
      state_d    = ISSUE;
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // The slot instruction is the next one delivered; the target takes effect after it.
    if (deliver) begin
      pend_vld_d = 1'b0;
      if (pend_vld_q) pc_d = pend_q;
    end
    if (redir_ok) begin
      misalign_d = |redirect_pc[1:0];
      if (deliver) begin
        pc_d = target;
      end else begin
        pend_d     = target;
        pend_vld_d = 1'b1;
      end
    end
`else
    if (redir_ok) begin
      pc_d       = target;
      id_valid_d = 1'b0;
      misalign_d = |redirect_pc[1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_instr_q <= 32'd0;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      kill_q     <= 1'b0;
      hold_q     <= 32'd0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q     <= 32'd0;
      pend_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
      kill_q     <= kill_d;
      hold_q     <= hold_d;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
`endif
    end
  end

  assign IF_PC     = pc_q;
  assign imem_req  = (state_q == ISSUE);
  assign imem_addr = pc_q;
  assign ID_PC     = id_pc_q;
  assign ID_instr  = id_instr_q;
  assign ID_valid  = id_valid_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory model.
// Expectations follow BRANCH_DELAY_SLOT_EN when that macro is defined for the build.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] IF_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ID_PC;
  logic [31:0] ID_instr;
  logic        ID_valid;
  logic        misalign;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cnt = 0;
  logic [31:0] mem_a = 32'd0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .IF_PC(IF_PC), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ID_PC(ID_PC), .ID_instr(ID_instr),
    .ID_valid(ID_valid), .misalign(misalign)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // rvalid appears `lat` cycles after the accepting cycle, one pulse per accept.
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= f(mem_a);
      end
    end
    if (imem_req && imem_ready) begin
      mem_a <= imem_addr;
      if (lat == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= f(imem_addr);
      end else begin
        cnt <= lat - 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick; tick;
    chk("rst_if_pc", IF_PC, 32'h3000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_id_pc", ID_PC, 32'd0);
    chk("rst_id_instr", ID_instr, 32'd0);
    chk("rst_id_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;
    $display("step: release reset");
    chk("c0_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h3000);
    tick;
    chk("c2_req", {31'd0, imem_req}, 32'd0);
    chk("c2_valid", {31'd0, ID_valid}, 32'd0);
    tick;
    $display("step: first delivery 0x3000");
    chk("c3_valid", {31'd0, ID_valid}, 32'd1);
    chk("c3_id_pc", ID_PC, 32'h3000);
    chk("c3_instr", ID_instr, f(32'h3000));
    chk("c3_if_pc", IF_PC, 32'h3004);
    chk("c3_addr", imem_addr, 32'h3004);
    tick;
    chk("c4_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("c5_id_pc", ID_PC, 32'h3004);
    chk("c5_instr", ID_instr, f(32'h3004));
    chk("c5_addr", imem_addr, 32'h3008);
    tick;
    $display("step: stall while rvalid for 0x3008");
    stall = 1'b1;
    tick;
    chk("hold_id_pc", ID_PC, 32'h3004);
    chk("hold_instr", ID_instr, f(32'h3004));
    chk("hold_if_pc", IF_PC, 32'h3008);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("hold2_instr", ID_instr, f(32'h3004));
    stall = 1'b0;
    tick;
    $display("step: buffered word released");
    chk("rel_id_pc", ID_PC, 32'h3008);
    chk("rel_instr", ID_instr, f(32'h3008));
    chk("rel_valid", {31'd0, ID_valid}, 32'd1);
    chk("rel_if_pc", IF_PC, 32'h300C);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    lat = 3;
    tick;
    $display("step: reset mid-fetch of 0x300C");
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_if_pc", IF_PC, 32'h3000);
    chk("rst2_valid", {31'd0, ID_valid}, 32'd0);
    chk("rst2_id_pc", ID_PC, 32'd0);
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("rst2_issue_addr", imem_addr, 32'h3000);
    lat = 1;
    tick;
    tick;
    chk("stray_id_pc", ID_PC, 32'h3000);
    chk("stray_instr", ID_instr, f(32'h3000));
    chk("stray_valid", {31'd0, ID_valid}, 32'd1);
    tick;
    tick;
    chk("seq_id_pc", ID_PC, 32'h3004);
    chk("seq_addr", imem_addr, 32'h3008);
    lat = 2;
    tick;
    $display("step: redirect to 0x4000 while 0x3008 outstanding");
    redirect = 1'b1;
    redirect_pc = 32'h4000;
    tick;
    redirect = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    chk("redir_valid", {31'd0, ID_valid}, 32'd1);
    chk("redir_if_pc", IF_PC, 32'h3008);
    tick;
    chk("slot_id_pc", ID_PC, 32'h3008);
    chk("slot_instr", ID_instr, f(32'h3008));
    chk("slot_valid", {31'd0, ID_valid}, 32'd1);
`else
    chk("redir_valid", {31'd0, ID_valid}, 32'd0);
    chk("redir_if_pc", IF_PC, 32'h4000);
    tick;
    chk("kill_valid", {31'd0, ID_valid}, 32'd0);
    chk("kill_instr", ID_instr, f(32'h3004));
`endif
    chk("tgt_req", {31'd0, imem_req}, 32'd1);
    chk("tgt_addr", imem_addr, 32'h4000);
    lat = 1;
    tick;
    tick;
    chk("tgt_id_pc", ID_PC, 32'h4000);
    chk("tgt_instr", ID_instr, f(32'h4000));
    chk("tgt_valid", {31'd0, ID_valid}, 32'd1);
    chk("tgt_addr2", imem_addr, 32'h4004);
    $display("step: redirect with stall in same cycle");
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h5000;
    tick;
    stall = 1'b0;
    redirect = 1'b0;
    chk("sr_if_pc", IF_PC, 32'h4004);
    chk("sr_misalign", {31'd0, misalign}, 32'd0);
    chk("sr_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("sr_id_pc", ID_PC, 32'h4004);
    chk("sr_instr", ID_instr, f(32'h4004));
    chk("sr_valid", {31'd0, ID_valid}, 32'd1);
    chk("sr_if_pc2", IF_PC, 32'h4008);
    $display("step: misaligned redirect to 0x4002");
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h4002;
    tick;
    redirect = 1'b0;
    imem_ready = 1'b1;
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("mis_addr", imem_addr, 32'h4008);
    chk("mis_valid", {31'd0, ID_valid}, 32'd1);
`else
    chk("mis_addr", imem_addr, 32'h4000);
    chk("mis_valid", {31'd0, ID_valid}, 32'd0);
`endif
    tick;
    chk("mis_once", {31'd0, misalign}, 32'd0);
    tick;
`ifdef BRANCH_DELAY_SLOT_EN
    chk("mis_id_pc", ID_PC, 32'h4008);
    chk("mis_if_pc", IF_PC, 32'h4000);
`else
    chk("mis_id_pc", ID_PC, 32'h4000);
    chk("mis_if_pc", IF_PC, 32'h4004);
`endif
    chk("mis_valid2", {31'd0, ID_valid}, 32'd1);
    $display("step: redirect to 0xFFFFFFFC and wrap");
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    imem_ready = 1'b1;
    chk("wrap_misalign", {31'd0, misalign}, 32'd0);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("wrap_slot_addr", imem_addr, 32'h4000);
    tick;
    tick;
    chk("wrap_slot_id_pc", ID_PC, 32'h4000);
    chk("wrap_pend_if_pc", IF_PC, 32'hFFFF_FFFC);
`else
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
`endif
    tick;
    tick;
    chk("wrap_id_pc", ID_PC, 32'hFFFF_FFFC);
    chk("wrap_instr", ID_instr, f(32'hFFFF_FFFC));
    chk("wrap_if_pc", IF_PC, 32'h0000_0000);
    chk("wrap_addr0", imem_addr, 32'h0000_0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
